pipeline_hazard_sequencer: RTL and testbench

//  Sequences pipeline stalls, bubbles, flushes and memory-wait freezes for the 5-stage MIPS pipeline.

---
 rtl/pipeline_hazard_sequencer_pkg.sv | 28 ++
 rtl/pipeline_hazard_sequencer_if.sv | 29 ++
 rtl/pipeline_hazard_sequencer_hz_sat_counter.sv | 21 ++
 rtl/pipeline_hazard_sequencer.sv | 148 ++++++++++++++
 tb/tb_pipeline_hazard_sequencer.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_sequencer_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM state encoding,
// branch opcodes and the branch-taken decode.
package pipeline_hazard_sequencer_pkg;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_LDSTALL = 2'd1,
    S_MEMWAIT = 2'd2
  } state_t;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQ   = 2'b01;
  localparam logic [1:0] BR_NE   = 2'b10;
  localparam logic [1:0] BR_JMP  = 2'b11;

  function automatic logic branch_taken(input logic [1:0] branch, input logic equal);
    logic taken;
    case (branch)
      BR_NONE: taken = 1'b0;
      BR_EQ:   taken = equal;
      BR_NE:   taken = ~equal;
      BR_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/pipeline_hazard_sequencer_if.sv
// Bundle between hazard detection / data memory (master) and the sequencer (slave).
interface pipeline_hazard_sequencer_if;

  // Handshake: dmem_req marks a MEM-stage access; the access completes in any
  // cycle where dmem_ready is also high. req without ready stalls the pipe.
  logic       ld_use_hz;
  logic [1:0] branch;
  logic       equal;
  logic       dmem_req;
  logic       dmem_ready;

  logic       pc_write;
  logic       IF_ID_write;
  logic       mux_hz_unit;
  logic       flush;
  logic       pipe_hold;
  logic       mem_err;

  modport master (
    output ld_use_hz, branch, equal, dmem_req, dmem_ready,
    input  pc_write, IF_ID_write, mux_hz_unit, flush, pipe_hold, mem_err
  );

  modport slave (
    input  ld_use_hz, branch, equal, dmem_req, dmem_ready,
    output pc_write, IF_ID_write, mux_hz_unit, flush, pipe_hold, mem_err
  );

endinterface

// File: rtl/pipeline_hazard_sequencer_hz_sat_counter.sv
// Saturating event counter for hazard statistics; only built with HZ_STATS_EN.
`ifdef HZ_STATS_EN
module pipeline_hazard_sequencer_hz_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/pipeline_hazard_sequencer.sv
// Stall / bubble / flush / memory-freeze sequencer for the 5-stage MIPS pipe.
// Define HZ_STATS_EN to add saturating bubble, flush and hold cycle counters.
module pipeline_hazard_sequencer
  import pipeline_hazard_sequencer_pkg::*;
#(
  parameter int LD_STALL_CYC = 1,
  parameter int MEM_TIMEOUT  = 15,
  parameter int CNT_W        = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  pipeline_hazard_sequencer_if.slave      hz,
  output state_t                          dbg_state
`ifdef HZ_STATS_EN
  ,
  output logic [CNT_W-1:0]                ld_stall_cnt,
  output logic [CNT_W-1:0]                flush_cnt,
  output logic [CNT_W-1:0]                mem_wait_cnt
`endif
);

  if ((LD_STALL_CYC < 1) || (LD_STALL_CYC > 7) ||
      (MEM_TIMEOUT < 1) || (MEM_TIMEOUT > 255) || (CNT_W < 1)) begin : g_bad_param
    $error("pipeline_hazard_sequencer: parameter out of range");
  end

  localparam logic [2:0] STALL_RELOAD = 3'(LD_STALL_CYC - 1);
  localparam logic [7:0] WAIT_LIMIT   = 8'(MEM_TIMEOUT);

  state_t     state, state_nx;
  logic [2:0] stall_cnt, stall_nx;
  logic [7:0] wait_cnt, wait_nx;
  logic       mem_err, err_set;
  logic       mem_stall, taken;
  logic       pc_w, ifid_w, mux_pass, flush_o, hold_o;

  assign mem_stall = hz.dmem_req & ~hz.dmem_ready;
  assign taken     = branch_taken(hz.branch, hz.equal);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_RUN;
      stall_cnt <= '0;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      stall_cnt <= stall_nx;
      wait_cnt  <= wait_nx;
      if (err_set) mem_err <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    stall_nx = stall_cnt;
    wait_nx  = wait_cnt;
    err_set  = 1'b0;
    pc_w     = 1'b1;
    ifid_w   = 1'b1;
    mux_pass = 1'b1;
    flush_o  = 1'b0;
    hold_o   = 1'b0;

    case (state)
      S_RUN: begin
        if (mem_stall) begin
          hold_o   = 1'b1;
          pc_w     = 1'b0;
          ifid_w   = 1'b0;
          wait_nx  = 8'd1;
          state_nx = S_MEMWAIT;
        end else if (hz.ld_use_hz) begin
          pc_w     = 1'b0;
          ifid_w   = 1'b0;
          mux_pass = 1'b0;
          if (LD_STALL_CYC > 1) begin
            stall_nx = STALL_RELOAD;
            state_nx = S_LDSTALL;
          end
        end else if (taken) begin
          flush_o = 1'b1;
        end
      end

      S_LDSTALL: begin
        // A memory freeze preempts the bubble; the remaining count is kept.
        if (mem_stall) begin
          hold_o   = 1'b1;
          pc_w     = 1'b0;
          ifid_w   = 1'b0;
          wait_nx  = 8'd1;
          state_nx = S_MEMWAIT;
        end else begin
          pc_w     = 1'b0;
          ifid_w   = 1'b0;
          mux_pass = 1'b0;
          stall_nx = (stall_cnt == 3'd0) ? 3'd0 : stall_cnt - 3'd1;
          if (stall_cnt <= 3'd1) state_nx = S_RUN;
        end
      end

      S_MEMWAIT: begin
        hold_o = 1'b1;
        pc_w   = 1'b0;
        ifid_w = 1'b0;
        if (hz.dmem_ready || (wait_cnt == WAIT_LIMIT)) begin
          err_set  = ~hz.dmem_ready;
          wait_nx  = 8'd0;
          state_nx = (stall_cnt != 3'd0) ? S_LDSTALL : S_RUN;
        end else begin
          wait_nx = wait_cnt + 8'd1;
        end
      end

      default: state_nx = S_RUN;
    endcase

    if (!rst_n) begin
      pc_w     = 1'b0;
      ifid_w   = 1'b0;
      mux_pass = 1'b0;
      flush_o  = 1'b0;
      hold_o   = 1'b0;
    end
  end

  assign hz.pc_write    = pc_w;
  assign hz.IF_ID_write = ifid_w;
  assign hz.mux_hz_unit = mux_pass;
  assign hz.flush       = flush_o;
  assign hz.pipe_hold   = hold_o;
  assign hz.mem_err     = mem_err;
  assign dbg_state      = state;

`ifdef HZ_STATS_EN
  pipeline_hazard_sequencer_hz_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk(clk), .rst_n(rst_n), .inc(rst_n & ~mux_pass), .count(ld_stall_cnt)
  );
  pipeline_hazard_sequencer_hz_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .inc(flush_o), .count(flush_cnt)
  );
  pipeline_hazard_sequencer_hz_sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
    .clk(clk), .rst_n(rst_n), .inc(hold_o), .count(mem_wait_cnt)
  );
`endif

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed bench for pipeline_hazard_sequencer (LD_STALL_CYC=3, MEM_TIMEOUT=15).
module tb_pipeline_hazard_sequencer;
  import pipeline_hazard_sequencer_pkg::*;

  // {pc_write, IF_ID_write, mux_hz_unit, flush, pipe_hold, mem_err}
  localparam logic [5:0] O_RST   = 6'b000000;
  localparam logic [5:0] O_NORM  = 6'b111000;
  localparam logic [5:0] O_BUB   = 6'b000000;
  localparam logic [5:0] O_FLUSH = 6'b111100;
  localparam logic [5:0] O_HOLD  = 6'b001010;
  localparam logic [5:0] O_ERR   = 6'b000001;

  logic   clk = 1'b0;
  logic   rst_n;
  state_t dbg_state;
  int     n_checks = 0;
  int     n_fail   = 0;

  pipeline_hazard_sequencer_if hz_if ();

`ifdef HZ_STATS_EN
  logic [15:0] ld_stall_cnt, flush_cnt, mem_wait_cnt;
`endif

  pipeline_hazard_sequencer #(
    .LD_STALL_CYC(3),
    .MEM_TIMEOUT (15),
    .CNT_W       (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .hz       (hz_if),
    .dbg_state(dbg_state)
`ifdef HZ_STATS_EN
    ,
    .ld_stall_cnt(ld_stall_cnt),
    .flush_cnt   (flush_cnt),
    .mem_wait_cnt(mem_wait_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // drivers: inputs change on the falling edge, outputs sampled 1 ns later
  task automatic drive(input logic ld, input logic [1:0] br, input logic eq,
                       input logic req, input logic rdy);
    @(negedge clk);
    hz_if.ld_use_hz  = ld;
    hz_if.branch     = br;
    hz_if.equal      = eq;
    hz_if.dmem_req   = req;
    hz_if.dmem_ready = rdy;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, BR_NONE, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_out(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {hz_if.pc_write, hz_if.IF_ID_write, hz_if.mux_hz_unit,
           hz_if.flush, hz_if.pipe_hold, hz_if.mem_err};
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input state_t exp);
    n_checks++;
    assert (dbg_state === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, dbg_state, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    hz_if.ld_use_hz  = 1'b0;
    hz_if.branch     = BR_NONE;
    hz_if.equal      = 1'b0;
    hz_if.dmem_req   = 1'b0;
    hz_if.dmem_ready = 1'b0;

    // reset held for two clocks
    idle();                       check_out("reset_c1", O_RST);
    idle();                       check_out("reset_c2", O_RST);
    check_state("reset_state", S_RUN);
    @(negedge clk); rst_n = 1'b1;
    idle();                       check_out("idle_run", O_NORM);

    // load-use: three bubbles, then run
    drive(1'b1, BR_NONE, 1'b0, 1'b0, 1'b0); check_out("ld_bub1", O_BUB);
    idle();                       check_out("ld_bub2", O_BUB);
    check_state("ld_state", S_LDSTALL);
    idle();                       check_out("ld_bub3", O_BUB);
    idle();                       check_out("ld_done", O_NORM);

    // branch decode
    drive(1'b0, BR_EQ, 1'b1, 1'b0, 1'b0);   check_out("beq_taken", O_FLUSH);
    drive(1'b0, BR_EQ, 1'b0, 1'b0, 1'b0);   check_out("beq_not", O_NORM);
    drive(1'b0, BR_NE, 1'b1, 1'b0, 1'b0);   check_out("bne_not", O_NORM);
    drive(1'b0, BR_NE, 1'b0, 1'b0, 1'b0);   check_out("bne_taken", O_FLUSH);
    drive(1'b0, BR_JMP, 1'b0, 1'b0, 1'b0);  check_out("jump", O_FLUSH);
    idle();                       check_out("after_br", O_NORM);

    // load-use beats jump; flush follows the stall
    drive(1'b1, BR_JMP, 1'b0, 1'b0, 1'b0);  check_out("ldj_bub1", O_BUB);
    drive(1'b0, BR_JMP, 1'b0, 1'b0, 1'b0);  check_out("ldj_bub2", O_BUB);
    drive(1'b0, BR_JMP, 1'b0, 1'b0, 1'b0);  check_out("ldj_bub3", O_BUB);
    drive(1'b0, BR_JMP, 1'b0, 1'b0, 1'b0);  check_out("ldj_flush", O_FLUSH);
    idle();                       check_out("ldj_done", O_NORM);

    // ready with request: no stall
    drive(1'b0, BR_NONE, 1'b0, 1'b1, 1'b1); check_out("mem_fast", O_NORM);

    // memory wait of four cycles, hold also covers the ready cycle
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, BR_NONE, 1'b0, 1'b1, 1'b0); check_out($sformatf("mw_hold%0d", i), O_HOLD);
    end
    check_state("mw_state", S_MEMWAIT);
    drive(1'b0, BR_NONE, 1'b0, 1'b1, 1'b1); check_out("mw_ready", O_HOLD);
    idle();                       check_out("mw_done", O_NORM);
    check_state("mw_exit_state", S_RUN);

    // memory freeze inside a load-use stall resumes the remaining bubbles
    drive(1'b1, BR_NONE, 1'b0, 1'b0, 1'b0); check_out("lm_bub1", O_BUB);
    drive(1'b0, BR_NONE, 1'b0, 1'b1, 1'b0); check_out("lm_hold", O_HOLD);
    drive(1'b0, BR_NONE, 1'b0, 1'b1, 1'b1); check_out("lm_ready", O_HOLD);
    idle();                       check_out("lm_bub2", O_BUB);
    check_state("lm_state", S_LDSTALL);
    idle();                       check_out("lm_bub3", O_BUB);
    idle();                       check_out("lm_done", O_NORM);

    // timeout: RUN cycle plus wait counts 1..15 are held
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, BR_NONE, 1'b0, 1'b1, 1'b0); check_out($sformatf("to_hold%0d", i), O_HOLD);
    end
    idle();                       check_out("to_release", O_NORM | O_ERR);
    idle();                       check_out("to_sticky", O_NORM | O_ERR);

    // reset during a wait clears everything
    drive(1'b0, BR_NONE, 1'b0, 1'b1, 1'b0); check_out("rw_hold", O_HOLD | O_ERR);
    drive(1'b0, BR_NONE, 1'b0, 1'b1, 1'b0); check_out("rw_hold2", O_HOLD | O_ERR);
    @(negedge clk); rst_n = 1'b0; #1;
    check_out("rw_rst_comb", O_RST | O_ERR);
    idle();                       check_out("rw_rst", O_RST);
`ifdef HZ_STATS_EN
    n_checks++;
    assert ({ld_stall_cnt, flush_cnt, mem_wait_cnt} === 48'd0) else begin
      n_fail++;
      $error("FAIL stats_reset observed=%0h expected=0", {ld_stall_cnt, flush_cnt, mem_wait_cnt});
    end
`endif
    @(negedge clk); rst_n = 1'b1;
    idle();                       check_out("rw_run", O_NORM);
    check_state("rw_state", S_RUN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
